// File: rtl/sample_accumulator.sv
// sample_accumulator: sums each block of 2^DIV_LOG2 unsigned samples and
// presents the exact full-precision sum on a registered valid/ready output.
// Feeds the rounding divide-by-2^DIV_LOG2 stage directly (block averager).
module sample_accumulator #(
  parameter int unsigned DIV_LOG2   = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SUM_WIDTH  = DATA_WIDTH + DIV_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [SUM_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  logic [SUM_WIDTH-1:0] acc;
  logic [DIV_LOG2-1:0]  cnt;
  logic [SUM_WIDTH-1:0] sum;
  logic                 last;
  logic                 accept;
  logic                 final_beat;
  logic                 out_take;

  // Beat bookkeeping and input-side flow control. Only the completing beat
  // needs output space; earlier beats of a block keep accumulating during a stall.
  always_comb begin
    last       = (cnt == '1);
    sum        = acc + SUM_WIDTH'(din);
    din_ready  = !clear && (!last || !dout_valid || dout_ready);
    accept     = din_valid && din_ready;
    final_beat = accept && last;
    out_take   = dout_valid && dout_ready;
  end

  // Running sum and in-block sample counter; clear discards the partial block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + DIV_LOG2'(1);
      end
    end
  end

  // Output register: loads on the completing beat, drops valid only on a
  // handshake with no new sum arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (final_beat) begin
      dout       <= sum;
      dout_valid <= 1'b1;
    end else if (out_take) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_accumulator.sv
// tb_sample_accumulator: directed vectors with hand-computed sums plus a
// randomized gap/backpressure run checked against a scoreboard.
module tb_sample_accumulator;

  localparam int unsigned DIV_LOG2   = 3;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned SUM_WIDTH  = 11;

  logic                  clk;
  logic                  reset;
  logic                  clear;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic [SUM_WIDTH-1:0]  dout;
  logic                  dout_valid;
  logic                  dout_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned stalls   = 0;

  // scoreboard state for the random phase
  logic        sb_on = 1'b0;
  int unsigned m_sum = 0;
  int unsigned m_cnt = 0;
  int unsigned n_beats = 0;
  int unsigned n_blocks = 0;
  int unsigned exp_q[$];
  logic        prev_stall = 1'b0;
  logic [SUM_WIDTH-1:0] prev_dout = '0;

  sample_accumulator #(
    .DIV_LOG2  (DIV_LOG2),
    .DATA_WIDTH(DATA_WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one sample and hold it until accepted (bounded)
  task automatic beat(input logic [7:0] v);
    int unsigned t;
    din       = v;
    din_valid = 1'b1;
    t         = 0;
    @(negedge clk);
    if (!din_ready) stalls++;
    while (!din_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("beat_accept", 32'(din_ready), 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic block(input logic [7:0] v);
    for (int i = 0; i < 8; i++) beat(v);
  endtask

  // scoreboard: observes accepted beats and output handshakes at the negedge
  always @(negedge clk) begin
    if (sb_on && !reset) begin
      if (prev_stall) begin
        check("stall_hold", 32'(dout), 32'(prev_dout));
        check("stall_valid", 32'(dout_valid), 32'd1);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) check("blk_extra", 32'(dout), 32'hFFFF_FFFF);
        else check("blk_sum", 32'(dout), exp_q.pop_front());
        n_blocks++;
      end
      if (din_valid && din_ready) begin
        m_sum += 32'(din);
        m_cnt++;
        n_beats++;
        if (m_cnt == 8) begin
          exp_q.push_back(m_sum);
          m_sum = 0;
          m_cnt = 0;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned cyc;
    reset      = 1'b1;
    clear      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    // 1..8 back to back
    stalls = 0;
    for (int i = 1; i <= 8; i++) beat(8'(i));
    @(negedge clk);
    check("seq_valid", 32'(dout_valid), 32'd1);
    check("seq_sum", 32'(dout), 32'd36);
    check("seq_nostall", stalls, 32'd0);
    tick();
    @(negedge clk);
    check("seq_pulse", 32'(dout_valid), 32'd0);
    tick();

    // full-scale and zero blocks
    block(8'd255);
    @(negedge clk);
    check("max_sum", 32'(dout), 32'd2040);
    check("max_valid", 32'(dout_valid), 32'd1);
    tick();
    block(8'd0);
    @(negedge clk);
    check("zero_sum", 32'(dout), 32'd0);
    check("zero_valid", 32'(dout_valid), 32'd1);
    tick();
    tick();

    // backpressure: A = 8x10 held, B = 8x3
    dout_ready = 1'b0;
    block(8'd10);
    @(negedge clk);
    check("bpA_sum", 32'(dout), 32'd80);
    tick();
    stalls = 0;
    for (int i = 0; i < 7; i++) beat(8'd3);
    check("bpB_nostall", stalls, 32'd0);
    din       = 8'd3;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rdy_low", 32'(din_ready), 32'd0);
      check("bp_hold", 32'(dout), 32'd80);
      check("bp_valid", 32'(dout_valid), 32'd1);
      tick();
    end
    dout_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(din_ready), 32'd1);
    check("bp_take_a", 32'(dout), 32'd80);
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    check("bpB_sum", 32'(dout), 32'd24);
    check("bpB_valid", 32'(dout_valid), 32'd1);
    tick();
    tick();

    // clear discards partial block and blocks the beat
    for (int i = 0; i < 3; i++) beat(8'd100);
    clear     = 1'b1;
    din       = 8'd100;
    din_valid = 1'b1;
    @(negedge clk);
    check("clr_ready", 32'(din_ready), 32'd0);
    tick();
    clear     = 1'b0;
    din_valid = 1'b0;
    block(8'd2);
    @(negedge clk);
    check("clr_sum", 32'(dout), 32'd16);
    tick();
    tick();

    // async reset mid-block, then with a pending sum
    for (int i = 0; i < 5; i++) beat(8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst1_valid", 32'(dout_valid), 32'd0);
    check("arst1_dout", 32'(dout), 32'd0);
    check("arst1_ready", 32'(din_ready), 32'd1);
    tick();
    reset      = 1'b0;
    dout_ready = 1'b0;
    block(8'd1);
    @(negedge clk);
    check("arst1_sum", 32'(dout), 32'd8);
    check("arst1_pend", 32'(dout_valid), 32'd1);
    tick();
    beat(8'd5);
    beat(8'd5);
    #2;
    reset = 1'b1;
    #1;
    check("arst2_valid", 32'(dout_valid), 32'd0);
    check("arst2_dout", 32'(dout), 32'd0);
    check("arst2_ready", 32'(din_ready), 32'd1);
    tick();
    reset      = 1'b0;
    dout_ready = 1'b1;
    block(8'd1);
    @(negedge clk);
    check("arst2_sum", 32'(dout), 32'd8);
    tick();
    tick();
    tick();

    // random gaps and backpressure over 1000 blocks
    sb_on = 1'b1;
    cyc   = 0;
    while (n_beats < 8000 && cyc < 40000) begin
      din_valid  = ($urandom_range(0, 3) != 0);
      din        = 8'($urandom);
      dout_ready = ($urandom_range(0, 1) != 0);
      tick();
      cyc++;
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    repeat (4) tick();
    check("rnd_beats", n_beats, 32'd8000);
    check("rnd_blocks", n_blocks, 32'd1000);
    check("rnd_drain", exp_q.size(), 32'd0);
    check("rnd_partial", m_cnt, 32'd0);
    sb_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
